// File: rtl/id_alu_issue_pkg.sv
// Shared ALU opcode, RV32I opcode and decoded-entry definitions for the
// ALU issue stage and its decoder.
package id_alu_issue_pkg;

    localparam int XLEN   = 32;
    localparam int RD_W   = 5;
    localparam int CTRL_W = 3;

    localparam logic [CTRL_W-1:0] ALU_ADD = 3'b000;
    localparam logic [CTRL_W-1:0] ALU_SUB = 3'b001;
    localparam logic [CTRL_W-1:0] ALU_OR  = 3'b010;
    localparam logic [CTRL_W-1:0] ALU_AND = 3'b011;
    localparam logic [CTRL_W-1:0] ALU_XOR = 3'b100;
    localparam logic [CTRL_W-1:0] ALU_SRA = 3'b101;
    localparam logic [CTRL_W-1:0] ALU_SRL = 3'b110;
    localparam logic [CTRL_W-1:0] ALU_SLL = 3'b111;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [XLEN-1:0]   a;
        logic [XLEN-1:0]   b;
        logic [RD_W-1:0]   rd;
        logic              illegal;
    } alu_entry_t;

    // funct3 -> ALU code; SLT/SLTU (010/011) are screened out by the caller.
    function automatic logic [CTRL_W-1:0] f3_to_ctrl(input logic [2:0] f3,
                                                     input logic       sub_sel,
                                                     input logic       sra_sel);
        logic [CTRL_W-1:0] code;
        case (f3)
            3'b000:  code = sub_sel ? ALU_SUB : ALU_ADD;
            3'b001:  code = ALU_SLL;
            3'b100:  code = ALU_XOR;
            3'b101:  code = sra_sel ? ALU_SRA : ALU_SRL;
            3'b110:  code = ALU_OR;
            3'b111:  code = ALU_AND;
            default: code = ALU_ADD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/id_alu_issue_decode.sv
// Combinational RV32I-to-ALU decoder: produces one buffer entry per instruction.
module alu_op_decode
    import id_alu_issue_pkg::*;
(
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_rs1,
    input  logic [31:0] i_rs2,
    output alu_entry_t  o_entry
);

    logic [6:0] w_opc;
    logic [2:0] w_f3;
    logic [6:0] w_f7;
    logic       w_slt;
    logic       w_shift;

    assign w_opc   = i_instr[6:0];
    assign w_f3    = i_instr[14:12];
    assign w_f7    = i_instr[31:25];
    assign w_slt   = (w_f3 == 3'b010) || (w_f3 == 3'b011);
    assign w_shift = (w_f3 == 3'b001) || (w_f3 == 3'b101);

    // Illegal encodings keep the all-zero default apart from the flag.
    always_comb begin
        o_entry = '0;
        case (w_opc)
            OPC_OP: begin
                if (!w_slt && (w_f7 == 7'b0000000 || w_f7 == 7'b0100000)) begin
                    o_entry.ctrl = f3_to_ctrl(w_f3, i_instr[30], i_instr[30]);
                    o_entry.a    = i_rs1;
                    o_entry.b    = i_rs2;
                    o_entry.rd   = i_instr[11:7];
                end else begin
                    o_entry.illegal = 1'b1;
                end
            end
            OPC_OPIMM: begin
                if (!w_slt) begin
                    o_entry.ctrl = f3_to_ctrl(w_f3, 1'b0, i_instr[30]);
                    o_entry.a    = i_rs1;
                    o_entry.b    = w_shift ? {27'b0, i_instr[24:20]}
                                           : {{20{i_instr[31]}}, i_instr[31:20]};
                    o_entry.rd   = i_instr[11:7];
                end else begin
                    o_entry.illegal = 1'b1;
                end
            end
            OPC_LUI: begin
                o_entry.ctrl = ALU_ADD;
                o_entry.b    = {i_instr[31:12], 12'b0};
                o_entry.rd   = i_instr[11:7];
            end
            OPC_AUIPC: begin
                o_entry.ctrl = ALU_ADD;
                o_entry.a    = i_pc;
                o_entry.b    = {i_instr[31:12], 12'b0};
                o_entry.rd   = i_instr[11:7];
            end
            default: o_entry.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_alu_issue.sv
// ALU issue stage: decodes one instruction per cycle into a 2-entry FIFO whose
// head entry drives the ALU outputs directly.
module id_alu_issue
    import id_alu_issue_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_rs1_data,
    input  logic [31:0] in_rs2_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [2:0]  ALU_CTRL,
    output logic [31:0] ALU_DataA,
    output logic [31:0] ALU_DataB,
    output logic [4:0]  out_rd,
    output logic        out_illegal
);

    localparam logic [1:0] CNT_FULL = DEPTH[1:0];

    alu_entry_t w_dec;
    alu_entry_t r_e0;
    alu_entry_t r_e1;
    logic [1:0] r_count;
    logic [1:0] w_count_next;
    logic       r_in_ready;
    logic       w_push;
    logic       w_pop;

    alu_op_decode u_dec (
        .i_instr (in_instr),
        .i_pc    (in_pc),
        .i_rs1   (in_rs1_data),
        .i_rs2   (in_rs2_data),
        .o_entry (w_dec)
    );

    assign out_valid = (r_count != 2'd0);
    assign in_ready  = r_in_ready;
    assign w_push    = in_valid && r_in_ready;
    assign w_pop     = out_valid && out_ready;

    always_comb begin
        w_count_next = r_count;
        if (flush) begin
            w_count_next = 2'd0;
        end else if (w_push && !w_pop) begin
            w_count_next = r_count + 2'd1;
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - 2'd1;
        end
    end

    // r_e0 is the head; it is left untouched when the FIFO drains so the
    // ALU outputs keep their last values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count    <= 2'd0;
            r_in_ready <= 1'b0;
            r_e0       <= '0;
            r_e1       <= '0;
        end else begin
            r_count    <= w_count_next;
            r_in_ready <= (w_count_next < CNT_FULL);
            if (!flush) begin
                if (w_push && (r_count == 2'd0 || (r_count == 2'd1 && w_pop))) begin
                    r_e0 <= w_dec;
                end else if (w_pop && r_count == 2'd2) begin
                    r_e0 <= r_e1;
                end
                if (w_push && r_count == 2'd1 && !w_pop) begin
                    r_e1 <= w_dec;
                end
            end
        end
    end

    assign ALU_CTRL    = r_e0.ctrl;
    assign ALU_DataA   = r_e0.a;
    assign ALU_DataB   = r_e0.b;
    assign out_rd      = r_e0.rd;
    assign out_illegal = r_e0.illegal;

endmodule

// File: tb/tb_id_alu_issue.sv
// Directed self-checking bench for id_alu_issue with hand-computed expectations.
module tb_id_alu_issue;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic [31:0] in_rs1_data = '0;
    logic [31:0] in_rs2_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [2:0]  ALU_CTRL;
    logic [31:0] ALU_DataA;
    logic [31:0] ALU_DataB;
    logic [4:0]  out_rd;
    logic        out_illegal;

    int checks = 0;
    int errors = 0;

    logic [72:0] obs;
    logic [72:0] exp_v;
    assign obs = {ALU_CTRL, ALU_DataA, ALU_DataB, out_rd, out_illegal};

    localparam logic [6:0] OP    = 7'b0110011;
    localparam logic [6:0] OPIMM = 7'b0010011;

    always #5 clk = ~clk;

    id_alu_issue #(.DEPTH(2)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .ALU_CTRL(ALU_CTRL), .ALU_DataA(ALU_DataA), .ALU_DataB(ALU_DataB),
        .out_rd(out_rd), .out_illegal(out_illegal)
    );

    function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] opc);
        return {f7, rs2, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] itype(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] opc);
        return {imm, rs1, f3, rd, opc};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] a, input logic [31:0] b);
        in_valid    = 1'b1;
        in_instr    = instr;
        in_pc       = pc;
        in_rs1_data = a;
        in_rs2_data = b;
    endtask

    // Sends one instruction with out_ready=1, checks the presented entry one
    // cycle later, then lets it drain.
    task automatic test_one(input string name, input logic [31:0] instr,
                            input logic [31:0] pc, input logic [31:0] a,
                            input logic [31:0] b, input logic [72:0] expv);
        out_ready = 1'b1;
        drive(instr, pc, a, b);
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || obs !== expv) begin
            errors++;
            $display("FAIL %s: valid=%b got=%h required valid=1 %h", name, out_valid, obs, expv);
        end else $display("ok   %s: %h", name, obs);
        step();
        checks++;
        if (out_valid !== 1'b0 || obs !== expv) begin
            errors++;
            $display("FAIL %s_drain: valid=%b got=%h required valid=0 %h", name, out_valid, obs, expv);
        end else $display("ok   %s_drain", name);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #2;
        checks++;
        if ({out_valid, in_ready, obs} !== 75'd0) begin
            errors++;
            $display("FAIL reset: valid=%b ready=%b out=%h required all 0", out_valid, in_ready, obs);
        end else $display("ok   reset");
        step();
        rst = 1'b1;
        step();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: ready=%b valid=%b required 1 0", in_ready, out_valid);
        end else $display("ok   reset_release");
    endtask

    task automatic test_decode();
        test_one("add", rtype(7'h00, 5'd2, 5'd1, 3'b000, 5'd3, OP), 32'h0, 32'd5, 32'd7,
                 {3'b000, 32'd5, 32'd7, 5'd3, 1'b0});
        test_one("srai", itype({7'b0100000, 5'd31}, 5'd1, 3'b101, 5'd4, OPIMM), 32'h0,
                 32'h8000_0000, 32'd9, {3'b101, 32'h8000_0000, 32'd31, 5'd4, 1'b0});
        test_one("sub", rtype(7'h20, 5'd2, 5'd1, 3'b000, 5'd5, OP), 32'h0, 32'd20, 32'd8,
                 {3'b001, 32'd20, 32'd8, 5'd5, 1'b0});
        test_one("or", rtype(7'h00, 5'd2, 5'd1, 3'b110, 5'd6, OP), 32'h0, 32'hF0, 32'h0F,
                 {3'b010, 32'hF0, 32'h0F, 5'd6, 1'b0});
        test_one("and", rtype(7'h00, 5'd2, 5'd1, 3'b111, 5'd7, OP), 32'h0, 32'h11, 32'h22,
                 {3'b011, 32'h11, 32'h22, 5'd7, 1'b0});
        test_one("xor", rtype(7'h00, 5'd2, 5'd1, 3'b100, 5'd8, OP), 32'h0, 32'h33, 32'h44,
                 {3'b100, 32'h33, 32'h44, 5'd8, 1'b0});
        test_one("sll", rtype(7'h00, 5'd2, 5'd1, 3'b001, 5'd9, OP), 32'h0, 32'h1, 32'h4,
                 {3'b111, 32'h1, 32'h4, 5'd9, 1'b0});
        test_one("srl", rtype(7'h00, 5'd2, 5'd1, 3'b101, 5'd10, OP), 32'h0, 32'h80, 32'h3,
                 {3'b110, 32'h80, 32'h3, 5'd10, 1'b0});
        test_one("addi", itype(12'hFFF, 5'd1, 3'b000, 5'd11, OPIMM), 32'h0, 32'd42, 32'd99,
                 {3'b000, 32'd42, 32'hFFFF_FFFF, 5'd11, 1'b0});
        test_one("auipc", {20'h12345, 5'd12, 7'b0010111}, 32'h100, 32'd1, 32'd2,
                 {3'b000, 32'h100, 32'h1234_5000, 5'd12, 1'b0});
        test_one("lui", {20'hABCDE, 5'd13, 7'b0110111}, 32'h200, 32'd1, 32'd2,
                 {3'b000, 32'h0, 32'hABCD_E000, 5'd13, 1'b0});
    endtask

    task automatic test_illegal();
        test_one("slt", rtype(7'h00, 5'd2, 5'd1, 3'b010, 5'd9, OP), 32'h0, 32'd3, 32'd4,
                 {3'b000, 32'd0, 32'd0, 5'd0, 1'b1});
        test_one("load", itype(12'h004, 5'd1, 3'b010, 5'd9, 7'b0000011), 32'h0, 32'd3, 32'd4,
                 {3'b000, 32'd0, 32'd0, 5'd0, 1'b1});
        test_one("mul", rtype(7'h01, 5'd2, 5'd1, 3'b000, 5'd9, OP), 32'h0, 32'd3, 32'd4,
                 {3'b000, 32'd0, 32'd0, 5'd0, 1'b1});
    endtask

    task automatic test_back_to_back();
        logic [72:0] e1, e2, e3;
        e1 = {3'b000, 32'd1, 32'd2, 5'd1, 1'b0};
        e2 = {3'b100, 32'd3, 32'd4, 5'd2, 1'b0};
        e3 = {3'b010, 32'd5, 32'd6, 5'd3, 1'b0};
        out_ready = 1'b0;
        drive(rtype(7'h00, 5'd2, 5'd1, 3'b000, 5'd1, OP), 32'h0, 32'd1, 32'd2);
        step();
        checks++;
        if ({in_ready, out_valid} !== 2'b11 || obs !== e1) begin
            errors++;
            $display("FAIL b2b_1: ready=%b valid=%b out=%h required 1 1 %h", in_ready, out_valid, obs, e1);
        end else $display("ok   b2b_1");
        drive(rtype(7'h00, 5'd2, 5'd1, 3'b100, 5'd2, OP), 32'h0, 32'd3, 32'd4);
        step();
        checks++;
        if ({in_ready, out_valid} !== 2'b01 || obs !== e1) begin
            errors++;
            $display("FAIL b2b_full: ready=%b valid=%b out=%h required 0 1 %h", in_ready, out_valid, obs, e1);
        end else $display("ok   b2b_full");
        drive(rtype(7'h00, 5'd2, 5'd1, 3'b110, 5'd3, OP), 32'h0, 32'd5, 32'd6);
        step();
        checks++;
        if ({in_ready, out_valid} !== 2'b01 || obs !== e1) begin
            errors++;
            $display("FAIL b2b_stall: ready=%b valid=%b out=%h required 0 1 %h", in_ready, out_valid, obs, e1);
        end else $display("ok   b2b_stall");
        out_ready = 1'b1;
        step();
        checks++;
        if ({in_ready, out_valid} !== 2'b11 || obs !== e2) begin
            errors++;
            $display("FAIL b2b_pop1: ready=%b valid=%b out=%h required 1 1 %h", in_ready, out_valid, obs, e2);
        end else $display("ok   b2b_pop1");
        step();
        in_valid = 1'b0;
        checks++;
        if ({in_ready, out_valid} !== 2'b11 || obs !== e3) begin
            errors++;
            $display("FAIL b2b_pop2: ready=%b valid=%b out=%h required 1 1 %h", in_ready, out_valid, obs, e3);
        end else $display("ok   b2b_pop2");
        step();
        checks++;
        if ({in_ready, out_valid} !== 2'b10 || obs !== e3) begin
            errors++;
            $display("FAIL b2b_empty: ready=%b valid=%b out=%h required 1 0 %h", in_ready, out_valid, obs, e3);
        end else $display("ok   b2b_empty");
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(rtype(7'h00, 5'd2, 5'd1, 3'b000, 5'd1, OP), 32'h0, 32'd1, 32'd2);
        step();
        step();
        checks++;
        if ({in_ready, out_valid} !== 2'b01) begin
            errors++;
            $display("FAIL flush_fill: ready=%b valid=%b required 0 1", in_ready, out_valid);
        end else $display("ok   flush_fill");
        flush = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_full: valid=%b required 0", out_valid);
        end else $display("ok   flush_full");
        // in_valid stays high: this cycle is an accept that flush must override.
        step();
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL flush_accept: ready=%b valid=%b required 1 0", in_ready, out_valid);
        end else $display("ok   flush_accept");
        flush = 1'b0;
        in_valid = 1'b0;
        step();
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL flush_after: ready=%b valid=%b required 1 0", in_ready, out_valid);
        end else $display("ok   flush_after");
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        drive(rtype(7'h00, 5'd2, 5'd1, 3'b111, 5'd4, OP), 32'h0, 32'd7, 32'd8);
        step();
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({out_valid, in_ready, obs} !== 75'd0) begin
            errors++;
            $display("FAIL reset_async: valid=%b ready=%b out=%h required all 0", out_valid, in_ready, obs);
        end else $display("ok   reset_async");
        step();
        rst = 1'b1;
        step();
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL reset_drop: ready=%b valid=%b required 1 0", in_ready, out_valid);
        end else $display("ok   reset_drop");
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_decode();
        test_illegal();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_alu_issue.md
ID_ALU_ISSUE -- requirements
Module: id_alu_issue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 2, meaning the output buffer entry count; only 2 is supported.
REQ-002 The block SHALL have port clk  input  1  rising-edge clock, the single clock of the block.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous assert, active-low.
REQ-004 The block SHALL have port flush  input  1  synchronous discard of all buffered entries.
REQ-005 The block SHALL have port in_valid  input  1  upstream instruction valid.
REQ-006 The block SHALL have port in_ready  output  1  block can accept an instruction.
REQ-007 The block SHALL have ports in_instr, in_pc, in_rs1_data, in_rs2_data  input  32 each  instruction word, its PC, register operands.
REQ-008 The block SHALL have port out_valid  output  1  issued ALU operation valid.
REQ-009 The block SHALL have port out_ready  input  1  ALU/EX stage accepts the operation.
REQ-010 The block SHALL have port ALU_CTRL  output  3  ALU operation code.
REQ-011 The block SHALL have ports ALU_DataA, ALU_DataB  output  32 each  ALU operands.
REQ-012 The block SHALL have port out_rd  output  5  destination register.
REQ-013 The block SHALL have port out_illegal  output  1  instruction not executable on the ALU.

Function
REQ-014 Decode SHALL emit ALU_CTRL codes: ADD 000, SUB 001, OR 010, AND 011, XOR 100, SRA 101, SRL 110, SLL 111.
REQ-015 OP (opcode 0110011) SHALL map funct3 000 to ADD, or to SUB when instr[30]=1; 110 OR; 111 AND; 100 XOR; 001 SLL; 101 SRL, or SRA when instr[30]=1; A=rs1, B=rs2.
REQ-016 OP-IMM (0010011) SHALL use the same funct3 map without SUB; B = sign-extended instr[31:20], except shifts, where B = {27'b0, instr[24:20]} and instr[30] selects SRA.
REQ-017 LUI (0110111) SHALL issue ADD with A=0 and B={instr[31:12],12'b0}; AUIPC (0010111) SHALL issue ADD with A=in_pc and the same B.
REQ-018 SLT/SLTU (funct3 010/011), all other opcodes, and OP with instr[31:25] not 0000000/0100000 SHALL issue with out_illegal=1, ALU_CTRL=000, and operands 0.
REQ-019 out_rd SHALL be instr[11:7] for legal operations and 0 when illegal.
REQ-020 A transfer SHALL occur on a cycle where valid and ready are both 1; an input transfer writes one decoded entry into the buffer.
REQ-021 Latency SHALL be 1 cycle: an instruction accepted at edge N SHALL be presented with out_valid=1 after edge N.
REQ-022 in_ready SHALL be a registered signal equal to (buffer count < 2), with no combinational path from out_ready.
REQ-023 Throughput SHALL be one instruction per cycle when out_ready is held 1.
REQ-024 Order SHALL be FIFO; outputs SHALL be driven from the head entry and held stable while out_valid=1 and out_ready=0.
REQ-025 A simultaneous accept and issue SHALL leave the count unchanged; at count 2 the input is not accepted because in_ready=0.
REQ-026 With count 0, out_valid SHALL be 0 and ALU outputs SHALL hold their last values.
REQ-027 flush SHALL set count to 0 and out_valid to 0 at the next edge, overriding a same-cycle accept, and in_ready SHALL be 1 on the following cycle.

Reset
REQ-028 While rst=0, count SHALL be 0, out_valid 0, in_ready 0, ALU_CTRL 000, ALU_DataA/B 0, out_rd 0, and out_illegal 0, asynchronously.
REQ-029 in_ready SHALL rise on the first edge after rst deasserts; reset during a transfer SHALL drop that entry.

Structure
REQ-030 ALU_CTRL code constants, RV32I opcode constants, and the decoded-entry field widths SHALL live in the shared defines file.
REQ-031 Decode SHALL be a combinational sub-module alu_op_decode, instantiated once; the top holds the 2-entry buffer and handshake.

Verification
REQ-032 Reset then ADD x3,x1,x2 with rs1=5, rs2=7, out_ready=1 -> one cycle later ALU_CTRL=000, A=5, B=7, out_rd=3, out_illegal=0.
REQ-033 SRAI x4,x1,31 (instr[30]=1) -> ALU_CTRL=101, B=31; SUB -> 001; OR/AND/XOR -> 010/011/100.
REQ-034 ADDI with imm=0xFFF -> B=0xFFFFFFFF; AUIPC imm 0x12345 at pc=0x100 -> ADD, A=0x100, B=0x12345000.
REQ-035 out_ready=0 with 3 back-to-back inputs -> in_ready=0 after two accepts, outputs stable; then release -> all issue in order, none lost.
REQ-036 SLT, then opcode 0000011 -> out_illegal=1, out_rd=0; flush at count 2 with in_valid=1 -> out_valid=0 next cycle, in_ready=1 the cycle after.
